// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters.
// Round-robin arbitration picks one pending command in IDLE, drives it through
// SETUP and ACCESS, and returns the result to the owner with a one-cycle done
// pulse in COMPLETE. A wait counter aborts an ACCESS the slave never finishes.
module apb_master_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SETUP    = 2'd1;
    localparam logic [1:0] ACCESS   = 2'd2;
    localparam logic [1:0] COMPLETE = 2'd3;

    localparam int              CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q,      state_d;
    logic              owner_q,      owner_d;
    logic              lastServed_q, lastServed_d;
    logic              pwrite_q,     pwrite_d;
    logic [ADDR_W-1:0] paddr_q,      paddr_d;
    logic [DATA_W-1:0] pwdata_q,     pwdata_d;
    logic [CNT_W-1:0]  waitCnt_q,    waitCnt_d;
    logic [DATA_W-1:0] rdata0_q,     rdata0_d;
    logic [DATA_W-1:0] rdata1_q,     rdata1_d;
    logic              err0_q,       err0_d;
    logic              err1_q,       err1_d;
    logic              grant;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~lastServed_q;
        end else begin
            grant = req1_valid;
        end
    end

    // Next-state logic for the transfer FSM, latched command and owner results.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lastServed_d = lastServed_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        waitCnt_d    = waitCnt_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    owner_d  = grant;
                    pwrite_d = grant ? req1_write : req0_write;
                    paddr_d  = grant ? req1_addr  : req0_addr;
                    pwdata_d = grant ? req1_wdata : req0_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                waitCnt_d = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    if (owner_q) begin
                        if (!pwrite_q) rdata1_d = prdata;
                        err1_d = 1'b0;
                    end else begin
                        if (!pwrite_q) rdata0_d = prdata;
                        err0_d = 1'b0;
                    end
                    state_d = COMPLETE;
                end else if (waitCnt_q == LAST_WAIT) begin
                    if (owner_q) begin
                        rdata1_d = '0;
                        err1_d   = 1'b1;
                    end else begin
                        rdata0_d = '0;
                        err0_d   = 1'b1;
                    end
                    state_d = COMPLETE;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end
            COMPLETE: begin
                lastServed_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any transfer and makes req0 win the first tie.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            lastServed_q <= 1'b1;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            waitCnt_q    <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lastServed_q <= lastServed_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            waitCnt_q    <= waitCnt_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
        end
    end

    assign psel       = (state_q == SETUP) || (state_q == ACCESS);
    assign penable    = (state_q == ACCESS);
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign req0_done  = (state_q == COMPLETE) && !owner_q;
    assign req1_done  = (state_q == COMPLETE) &&  owner_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign req0_err   = err0_q;
    assign req1_err   = err1_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios plus a
// randomized run, compared against a transaction-level reference model.
module tb_apb_master_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              pclk = 1'b0;
    logic              presetn;
    logic              req0_valid, req0_write, req0_done, req0_err;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata, req0_rdata;
    logic              req1_valid, req1_write, req1_done, req1_err;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata, req1_rdata;
    logic              psel, penable, pwrite, pready;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata, prdata;

    int nVectors     = 0;
    int nMiscompares = 0;

    // reference model: memory contents, per-requester results, last served
    logic [DATA_W-1:0] refMem [8];
    logic [DATA_W-1:0] expRdata [2];
    logic              expErr [2];
    int                refLast;

    // slave model state
    logic [DATA_W-1:0] slaveMem [8];
    int                readyDelay = 1;
    int                accCnt     = 0;

    apb_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .presetn(presetn),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
        .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
        .req1_err(req1_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    // APB slave: ready after readyDelay ACCESS cycles, random pready outside ACCESS
    always @(negedge pclk) begin
        if (psel && penable) begin
            accCnt = accCnt + 1;
            pready = (accCnt >= readyDelay);
            if (pready && pwrite) slaveMem[paddr[4:2]] = pwdata;
        end else begin
            accCnt = 0;
            pready = 1'($urandom_range(0, 1));
        end
        prdata = slaveMem[paddr[4:2]];
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nVectors++;
        if (observed !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic w0, input logic [ADDR_W-1:0] a0,
                                 input logic [DATA_W-1:0] d0, input logic v1, input logic w1,
                                 input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
    endtask

    function automatic logic [ADDR_W-1:0] randAddr();
        return ADDR_W'($urandom_range(0, 7)) << 2;
    endfunction

    function automatic void resetModel();
        refLast     = 1;
        expRdata[0] = '0;
        expRdata[1] = '0;
        expErr[0]   = 1'b0;
        expErr[1]   = 1'b0;
    endfunction

    // Runs one transfer starting at an IDLE negedge; ends at the IDLE negedge after done.
    task automatic doTransfer(input int delay, output int owner);
        int                expOwner, expAcc, expIdx, cnt;
        logic              expWrite, expAbort;
        logic [ADDR_W-1:0] expAddr;
        logic [DATA_W-1:0] expWdata;
        readyDelay = delay;
        if (req0_valid && req1_valid) expOwner = (refLast == 1) ? 0 : 1;
        else                          expOwner = req1_valid ? 1 : 0;
        expWrite = expOwner ? req1_write : req0_write;
        expAddr  = expOwner ? req1_addr  : req0_addr;
        expWdata = expOwner ? req1_wdata : req0_wdata;
        expIdx   = int'(expAddr[4:2]);
        expAbort = (delay > TIMEOUT);
        expAcc   = expAbort ? TIMEOUT : delay;

        @(negedge pclk);
        checkOutput("setup_phase", {psel, penable, req0_done, req1_done}, 4'b1000);
        checkOutput("setup_paddr", paddr, expAddr);
        checkOutput("setup_pwrite", pwrite, expWrite);
        checkOutput("setup_pwdata", pwdata, expWdata);
        if (expOwner == 0) begin
            req0_addr = $urandom; req0_wdata = $urandom; req0_write = ~req0_write;
        end else begin
            req1_addr = $urandom; req1_wdata = $urandom; req1_write = ~req1_write;
        end

        cnt = 0;
        for (int i = 0; i < TIMEOUT + 8; i++) begin
            @(negedge pclk);
            if (!(psel && penable)) break;
            cnt++;
            checkOutput("access_paddr", paddr, expAddr);
            checkOutput("access_cmd", {pwrite, pwdata}, {expWrite, expWdata});
            checkOutput("access_no_done", {req0_done, req1_done}, 2'b00);
        end
        checkOutput("access_cycles", cnt, expAcc);

        if (!expAbort && expWrite) refMem[expIdx] = expWdata;
        if (expAbort) begin
            expRdata[expOwner] = '0;
            expErr[expOwner]   = 1'b1;
        end else begin
            if (!expWrite) expRdata[expOwner] = refMem[expIdx];
            expErr[expOwner] = 1'b0;
        end
        refLast = expOwner;

        checkOutput("complete_bus", {psel, penable}, 2'b00);
        checkOutput("complete_done", {req1_done, req0_done}, (expOwner == 1) ? 2'b10 : 2'b01);
        checkOutput("complete_rdata0", req0_rdata, expRdata[0]);
        checkOutput("complete_rdata1", req1_rdata, expRdata[1]);
        checkOutput("complete_err", {req1_err, req0_err}, {expErr[1], expErr[0]});
        owner = req1_done ? 1 : 0;

        @(negedge pclk);
        checkOutput("idle_gap", {psel, penable, req0_done, req1_done}, 4'b0000);
    endtask

    // Directed scenarios followed by a randomized run.
    initial begin
        int   owner, dly;
        logic v0, v1;
        int   expOrder [4] = '{0, 1, 0, 1};

        for (int i = 0; i < 8; i++) begin
            refMem[i]   = $urandom;
            slaveMem[i] = refMem[i];
        end
        resetModel();
        presetn = 1'b0;
        pready  = 1'b0;
        prdata  = '0;
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
        repeat (2) @(negedge pclk);
        checkOutput("reset_ctrl", {psel, penable, pwrite, req0_done, req1_done, req0_err, req1_err}, 0);
        checkOutput("reset_paddr", paddr, 0);
        checkOutput("reset_pwdata", pwdata, 0);
        checkOutput("reset_rdata", {req0_rdata, req1_rdata}, 0);
        presetn = 1'b1;

        // write then read back through the other requester
        applyStimulus(1, 1, 32'h0, 32'hA5A5_1234, 0, 0, '0, '0);
        doTransfer(2, owner);
        checkOutput("wr_owner", owner, 0);
        applyStimulus(0, 0, '0, '0, 1, 0, 32'h0, '0);
        doTransfer(1, owner);
        checkOutput("rd_owner", owner, 1);
        checkOutput("rd_data", req1_rdata, 32'hA5A5_1234);

        // timeout abort, then ready on the final edge succeeds
        applyStimulus(1, 0, 32'h8, '0, 0, 0, '0, '0);
        doTransfer(1000, owner);
        checkOutput("timeout_err", {req0_err, req0_rdata}, {1'b1, 32'h0});
        applyStimulus(1, 0, 32'h0, '0, 0, 0, '0, '0);
        doTransfer(TIMEOUT, owner);
        checkOutput("last_edge_err", req0_err, 0);
        checkOutput("last_edge_rdata", req0_rdata, 32'hA5A5_1234);

        // reset in ACCESS, then contention with both valid held
        applyStimulus(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, '0, '0);
        readyDelay = 1000;
        repeat (3) @(negedge pclk);
        checkOutput("pre_reset_access", {psel, penable}, 2'b11);
        presetn = 1'b0;
        #1;
        checkOutput("reset_async", {psel, penable, req0_done, req1_done, req0_err, req1_err}, 0);
        checkOutput("reset_async_paddr", paddr, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            checkOutput("reset_no_done", {psel, req0_done, req1_done}, 0);
        end
        presetn = 1'b1;
        resetModel();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'($urandom_range(0, 1)), randAddr(), $urandom,
                          1, 1'($urandom_range(0, 1)), randAddr(), $urandom);
            doTransfer(int'($urandom_range(1, 4)), owner);
            checkOutput("rr_order", owner, expOrder[i]);
        end

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            applyStimulus(v0, 1'($urandom_range(0, 1)), randAddr(), $urandom,
                          v1, 1'($urandom_range(0, 1)), randAddr(), $urandom);
            dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20))
                                               : int'($urandom_range(1, 5));
            doTransfer(dly, owner);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

    // Global time bound so a stuck design cannot hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time bound");
        $fatal(1);
    end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 32, address width.
- DATA_W, default 32, data width.
- TIMEOUT, default 16, max ACCESS cycles before abort (>=2).
REQ-002 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- pclk  in  1  APB clock.
- presetn  in  1  async active-low reset.
- reqN_valid  in  1  requester N (N=0,1) command pending.
- reqN_write  in  1  1=write, 0=read.
- reqN_addr  in  ADDR_W  target address.
- reqN_wdata  in  DATA_W  write data.
- reqN_done  out  1  one-cycle completion pulse.
- reqN_rdata  out  DATA_W  read data.
- reqN_err  out  1  timeout flag, valid with done.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB slave ready.

Function
REQ-004 The FSM SHALL have states IDLE, SETUP, ACCESS, COMPLETE.
REQ-005 IDLE: psel=0, penable=0; if any reqN_valid=1 at the rising edge, latch the winner's write/addr/wdata and owner id, then go to SETUP.
REQ-006 Arbitration SHALL be round-robin: single valid wins; both valid -> the requester not served last wins; the last-served pointer resets to 1 (req0 wins the first tie).
REQ-007 SETUP: psel=1, penable=0, lasting exactly one cycle, then ACCESS; pready SHALL be ignored in SETUP.
REQ-008 ACCESS: psel=1, penable=1, and paddr/pwrite/pwdata SHALL be held stable from SETUP until exit.
REQ-009 In ACCESS with pready=1 at the edge: capture prdata into the owner's reqN_rdata on reads (unchanged on writes), set reqN_err=0, go to COMPLETE.
REQ-010 A wait counter SHALL count ACCESS cycles. If TIMEOUT cycles elapse with pready=0: abort, set owner reqN_err=1 and reqN_rdata=0, go to COMPLETE.
REQ-011 COMPLETE: psel=0, penable=0, owner reqN_done=1 for exactly this cycle, update the last-served pointer, then IDLE.
REQ-012 reqN_done SHALL never assert for both requesters in the same cycle; the non-owner's outputs SHALL hold.
REQ-013 A requester SHALL hold valid and command stable until its done. Valid or command changes after latch SHALL be ignored for the current transfer.
REQ-014 Valid sampled in IDLE only: a requester that drops valid in its done cycle SHALL NOT be served twice.
REQ-015 Minimum latency SHALL be: valid sampled at edge k -> SETUP cycle k+1 -> ACCESS cycle k+2 -> done in the cycle after the pready edge; back-to-back transfers insert one IDLE cycle.
REQ-016 pready=1 on the same edge as timeout expiry SHALL count as success (err=0).

Reset
REQ-017 presetn=0 SHALL immediately force state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, all reqN_done=0, reqN_err=0, reqN_rdata=0, wait counter=0, last-served=1.
REQ-018 Reset mid-transfer SHALL abandon the transfer with no done pulse. After release, pending valids SHALL be arbitrated from IDLE.

Verification
REQ-019 Write: req0 write addr 0x0 data 0xA5A5_1234, slave pready after 2 ACCESS cycles -> SETUP 1 cycle, ACCESS 2 cycles, pwdata=0xA5A5_1234, req0_done 1 cycle, err=0.
REQ-020 Read-back: req1 read addr 0x0 after REQ-019 write -> req1_rdata=0xA5A5_1234 with req1_done, req0_done stays 0.
REQ-021 Contention: both valid continuously for 4 transfers from reset -> grant order 0,1,0,1, one IDLE cycle between transfers.
REQ-022 Timeout: pready tied 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, done with err=1, rdata=0; pready on the 16th edge -> err=0.
REQ-023 Reset: presetn low during ACCESS -> psel/penable 0 immediately, no done; after release a held req0_valid is re-served normally.
REQ-024 Stability: req0_addr changed during ACCESS -> paddr unchanged until COMPLETE.
